// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with memory-ready wait states, a wait watchdog and illegal-op trap.
// Optional feature macro: MIPS_MC_BNE_EN (adds bne as a branch opcode).
module mips_mc_ctrl #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       PCEn,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] p_state,
    output logic       illegal,
    output logic       timeout
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXEC     = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11,
        ERR      = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             funct_ok;
    logic             take_br;
    logic             irw, pce, rw, mw, mr, ill;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        funct_ok = 1'b0;
        case (Funct)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
            default: funct_ok = 1'b0;
        endcase
    end

`ifdef MIPS_MC_BNE_EN
    assign take_br = (Op == OP_BNE) ? ~zero : zero;
`else
    assign take_br = zero;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        irw        = 1'b0;
        pce        = 1'b0;
        rw         = 1'b0;
        mw         = 1'b0;
        mr         = 1'b0;
        ill        = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ALUControl = 3'b000;
        unique case (state_q)
            FETCH: begin
                mr         = 1'b1;
                ALUSrcB    = 2'b01;
                ALUControl = 3'b010;
                if (mem_ready) begin
                    irw     = 1'b1;
                    pce     = 1'b1;
                    state_d = DECODE;
                end else if (cnt_q == CNT_W'(WAIT_LIMIT - 1)) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = 3'b010;
                if (Op == OP_LW || Op == OP_SW)      state_d = MEMADR;
                else if (Op == OP_RTYPE && funct_ok) state_d = EXEC;
                else if (Op == OP_BEQ)               state_d = BRANCH;
`ifdef MIPS_MC_BNE_EN
                else if (Op == OP_BNE)               state_d = BRANCH;
`endif
                else if (Op == OP_ADDI)              state_d = ADDIEXEC;
                else if (Op == OP_J)                 state_d = JUMP;
                else begin
                    ill     = 1'b1;
                    state_d = FETCH;
                end
            end
            MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = 3'b010;
                state_d    = (Op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD, MEMWR: begin
                mr = (state_q == MEMRD);
                mw = (state_q == MEMWR);
                if (mem_ready) state_d = (state_q == MEMRD) ? MEMWB : FETCH;
                else if (cnt_q == CNT_W'(WAIT_LIMIT - 1)) state_d = ERR;
                else cnt_d = cnt_q + 1'b1;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                rw       = 1'b1;
                state_d  = FETCH;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                case (Funct)
                    6'b100010: ALUControl = 3'b110;
                    6'b100100: ALUControl = 3'b000;
                    6'b100101: ALUControl = 3'b001;
                    6'b101010: ALUControl = 3'b111;
                    default:   ALUControl = 3'b010;
                endcase
                state_d = ALUWB;
            end
            ALUWB: begin
                RegDst  = 1'b1;
                rw      = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = 3'b110;
                PCSrc      = 2'b01;
                pce        = take_br;
                state_d    = FETCH;
            end
            ADDIEXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = 3'b010;
                state_d    = ADDIWB;
            end
            ADDIWB: begin
                rw      = 1'b1;
                state_d = FETCH;
            end
            JUMP: begin
                PCSrc   = 2'b10;
                pce     = 1'b1;
                state_d = FETCH;
            end
            ERR:     state_d = ERR;
            default: state_d = FETCH;
        endcase
    end

    // Strobes are masked while reset is held so nothing writes during an async reset.
    assign IRWrite  = irw & reset;
    assign PCEn     = pce & reset;
    assign RegWrite = rw & reset;
    assign MemWrite = mw & reset;
    assign MemRead  = mr & reset;
    assign illegal  = ill & reset;
    assign timeout  = (state_q == ERR);
    assign p_state  = state_q;

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Second-generation multicycle MIPS control unit for the mips_vf datapath.
- Adds a memory ready handshake with wait states on instruction fetch, load and store.
- Adds a parametrised wait-timeout watchdog, addi/j support, and illegal-opcode detection.
- Drives the existing datapath enables and mux selects. p_state keeps the existing state encoding so current benches still work.

Parameters:
WAIT_LIMIT, 15, max consecutive cycles a memory state may wait on mem_ready before timeout (1..255)
CNT_W, 8, wait counter width; must satisfy 2**CNT_W > WAIT_LIMIT

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Op  input  6  instruction opcode, InstrReg[31:26]
Funct  input  6  function field, InstrReg[5:0]
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
IRWrite  output  1  instruction register load enable
RegDst  output  1  1 = write rd, 0 = write rt
MemtoReg  output  1  1 = write-back from ReadData
RegWrite  output  1  register file write enable
ALUSrcA  output  1  0 = PC, 1 = A
MemWrite  output  1  data memory write strobe
MemRead  output  1  memory read request, fetch or load
PCEn  output  1  PC register enable
ALUSrcB  output  2  00 = B, 01 = const 1, 10/11 = SignImm
PCSrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = PCJump
ALUControl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
p_state  output  4  current state encoding
illegal  output  1  one-cycle pulse in DECODE on unsupported Op/Funct
timeout  output  1  sticky; set on entering ERR

Behaviour:
- Reset (reset=0, async):
  - state=FETCH (0), wait counter=0, timeout=0.
  - IRWrite, PCEn, RegWrite, MemWrite, MemRead, illegal forced 0; p_state=0.
- All outputs are combinational from state (plus mem_ready, zero, Funct). Control outputs not listed for a state are 0.
- FETCH (0): MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00.
  - mem_ready=1: IRWrite=1, PCEn=1, go to DECODE.
  - mem_ready=0: stay, increment counter.
- DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUControl=010. Next state by Op:
  - 100011/101011 -> MEMADR
  - 000000 with legal Funct -> EXEC. Legal Funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - 000100 -> BRANCH; 001000 -> ADDIEXEC; 000010 -> JUMP.
  - Anything else -> illegal=1, go to FETCH. No architectural write occurs.
- MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUControl=010. Go to MEMRD if Op=100011, else MEMWR.
- MEMRD (3): MemRead=1. mem_ready=1 -> MEMWB; else stay and count.
- MEMWB (4): RegDst=0, MemtoReg=1, RegWrite=1, go to FETCH.
- MEMWR (5): MemWrite=1 held until mem_ready=1, then FETCH; else stay and count.
- EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUControl from Funct, go to ALUWB.
- ALUWB (7): RegDst=1, MemtoReg=0, RegWrite=1, go to FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, PCEn=zero, go to FETCH.
- ADDIEXEC (9): ALUSrcA=1, ALUSrcB=10, ALUControl=010, go to ADDIWB.
- ADDIWB (10): RegDst=0, MemtoReg=0, RegWrite=1, go to FETCH.
- JUMP (11): PCSrc=10, PCEn=1, go to FETCH.
- ERR (15): all enables 0, timeout=1. Stays in ERR until reset.
- Wait counter:
  - Cleared on every state change and on any cycle where mem_ready=1.
  - In a wait state with mem_ready=0 and counter==WAIT_LIMIT-1: go to ERR next edge instead of incrementing.
  - WAIT_LIMIT cycles of mem_ready=0 therefore trap; mem_ready=1 on the final cycle completes normally.
- mem_ready is ignored outside FETCH/MEMRD/MEMWR.
- Reset mid-wait or mid-instruction: immediate return to FETCH; no write strobes asserted after reset falls.
- States 12-14 unreachable; if ever entered, go to FETCH.

Optional Feature:
MIPS_MC_BNE_EN
- Defined: Op=000101 (bne) is legal. DECODE -> BRANCH. In BRANCH, PCEn = zero for beq, ~zero for bne (Op still held in InstrReg).
- Undefined: Op=000101 is illegal (illegal pulse, return to FETCH); BRANCH uses PCEn = zero only.

Test Plan:
- reset low mid-MEMRD, release with mem_ready=1 -> p_state 0; first edge after release gives IRWrite=PCEn=1, p_state 0->1.
- add R-type (Op 000000, Funct 100000), mem_ready=1 always -> p_state 0,1,6,7,0; ALUControl=010 in state 6; RegWrite=1, RegDst=1 only in state 7.
- lw with mem_ready low 3 cycles in MEMRD -> p_state 0,1,2,3,3,3,3,4,0; MemRead high throughout state 3; RegWrite/MemtoReg=1 in state 4.
- sw with mem_ready held 0, WAIT_LIMIT=15 -> 15 cycles in state 5 with MemWrite=1, then p_state=15, timeout=1, stays until reset.
- beq with zero=1 then zero=0 -> PCEn=1 and PCSrc=01 in state 8 for the first; PCEn=0 for the second.
- Op=000101 -> MIPS_MC_BNE_EN off: illegal=1 for 1 cycle, back to p_state 0. On: state 8, PCEn=1 when zero=0.
